// File: rtl/axi_cmd_master.sv
// axi_cmd_master: AXI4 initiator turning single commands into INCR bursts with streamed write/read beats and a done pulse
module axi_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done_valid,
  output logic                  done_write,
  output logic [ID_WIDTH-1:0]   done_id,
  output logic [1:0]            done_resp,
  output logic                  busy,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int SIZE = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;
  state_t state, state_nx;
  logic write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0] len_q, cnt;
  logic [ID_WIDTH-1:0] id_q;
  logic [1:0] resp_acc, r_resp;
  logic cmd_hs, w_hs, r_hs, last_cnt;
  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};
  assign last_cnt = cnt == len_q;
  assign cmd_hs = cmd_valid && cmd_ready;
  assign w_hs = wr_valid && wr_ready;
  assign r_hs = rd_valid && rd_ready;
  assign r_resp = (m_axi_rlast != last_cnt) ? 2'b10 : (m_axi_rresp > resp_acc) ? m_axi_rresp : resp_acc;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = cmd_hs ? (cmd_write ? AW : AR) : IDLE;
      AW: state_nx = m_axi_awready ? W : AW;
      W: state_nx = (w_hs && last_cnt) ? B : W;
      B: state_nx = m_axi_bvalid ? DONE : B;
      AR: state_nx = m_axi_arready ? R : AR;
      R: state_nx = (r_hs && (m_axi_rlast || last_cnt)) ? DONE : R;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (cmd_hs) begin
      write_q <= cmd_write;
      addr_q <= cmd_addr & ALIGN;
      len_q <= cmd_len;
      id_q <= cmd_id;
      cnt <= '0;
      resp_acc <= '0;
    end
    if (w_hs || r_hs) cnt <= cnt + 8'd1;
    if (r_hs) resp_acc <= r_resp;
    if (state == B && m_axi_bvalid) resp_acc <= m_axi_bresp;
  end
  assign cmd_ready = state == IDLE && !rst;
  assign busy = state != IDLE;
  assign m_axi_awid = id_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_awlen = len_q;
  assign m_axi_awsize = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot = 3'b000;
  assign m_axi_awvalid = state == AW;
  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = wr_strb;
  assign m_axi_wlast = last_cnt;
  assign m_axi_wvalid = state == W && wr_valid;
  assign wr_ready = state == W && m_axi_wready;
  assign m_axi_bready = state == B;
  assign m_axi_arid = id_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_arlen = len_q;
  assign m_axi_arsize = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot = 3'b000;
  assign m_axi_arvalid = state == AR;
  assign m_axi_rready = state == R && rd_ready;
  assign rd_valid = state == R && m_axi_rvalid;
  assign rd_data = m_axi_rdata;
  assign rd_last = m_axi_rlast;
  assign done_valid = state == DONE;
  assign done_write = write_q;
  assign done_id = id_q;
  assign done_resp = resp_acc;
endmodule

// File: tb/tb_axi_cmd_master.sv
// tb_axi_cmd_master: randomized bench for axi_cmd_master with an AXI4 RAM slave and a command-level reference model
module tb_axi_cmd_master;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [15:0] cmd_addr = 0;
  logic [7:0] cmd_len = 0, cmd_id = 0;
  logic [31:0] wr_data = 0, rd_data;
  logic [3:0] wr_strb = 0;
  logic wr_valid = 0, wr_ready, rd_last, rd_valid, rd_ready = 0;
  logic done_valid, done_write, busy;
  logic [7:0] done_id;
  logic [1:0] done_resp;
  logic [7:0] awid, awlen, arid, arlen, bid, rid;
  logic [15:0] awaddr, araddr;
  logic [2:0] awsize, awprot, arsize, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, awvalid, awready, arlock, arvalid, arready;
  logic [3:0] awcache, arcache, wstrb;
  logic [31:0] wdata, rdata;
  logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  axi_cmd_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .done_valid(done_valid), .done_write(done_write), .done_id(done_id),
    .done_resp(done_resp), .busy(busy),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  int checks = 0, errors = 0, cyc = 0;
  bit active = 0, e_write = 0, lat_chk = 0, stall = 0;
  logic [15:0] e_addr = 0;
  logic [7:0] e_len = 0, e_id = 0;
  logic [1:0] e_resp = 0, bresp_cfg = 0, last_resp = 0;
  int early = -1, err_beat = -1;
  int w_seen = 0, r_seen = 0, done_cnt = 0, acc_cyc = -10;
  bit idle_exp = 1;
  logic [31:0] mm [int];
  logic [31:0] rd_log [0:255];
  logic [15:0] last_awaddr = 0;
  logic last_rd_last = 0;
  logic [31:0] cv;
  int cix;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm, input logic rdy);
    chk(nm, {awvalid, wvalid, bready, arvalid, rready, rd_valid, wr_ready, done_valid, busy, cmd_ready},
        {9'b0, rdy});
  endtask

  // AXI4 RAM slave: 1024 words, optional random ready/valid stalls, configurable error/early-last injection
  logic aw_have = 0, s_bvalid = 0, r_have = 0, s_rvalid = 0, s_rlast = 0, aw_r = 1, w_r = 1, ar_r = 1;
  logic [1:0] s_bresp = 0, s_rresp = 0;
  logic [15:0] waddr = 0, raddr = 0;
  logic [7:0] wlen = 0, wcnt = 0, rlen = 0, rcnt = 0;
  logic [31:0] s_rdata = 0;
  logic [31:0] smem [0:1023];
  assign awready = !aw_have && aw_r;
  assign wready = aw_have && !s_bvalid && w_r;
  assign bvalid = s_bvalid;
  assign bresp = s_bresp;
  assign bid = 8'h00;
  assign arready = !r_have && ar_r;
  assign rvalid = s_rvalid;
  assign rdata = s_rdata;
  assign rlast = s_rlast;
  assign rresp = s_rresp;
  assign rid = 8'h00;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    aw_r <= !stall || ($urandom_range(0, 2) != 0);
    w_r <= !stall || ($urandom_range(0, 2) != 0);
    ar_r <= !stall || ($urandom_range(0, 2) != 0);
    if (rst) begin
      aw_have <= 0;
      s_bvalid <= 0;
      r_have <= 0;
      s_rvalid <= 0;
      for (int i = 0; i < 1024; i++) smem[i] <= 0;
    end else begin
      if (awvalid && awready) begin
        aw_have <= 1;
        waddr <= awaddr;
        wlen <= awlen;
        wcnt <= 0;
      end
      if (wvalid && wready) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) smem[10'((waddr >> 2) + 16'(wcnt))][8*b +: 8] <= wdata[8*b +: 8];
        wcnt <= wcnt + 1;
        if (wcnt == wlen) begin
          s_bvalid <= 1;
          s_bresp <= bresp_cfg;
        end
      end
      if (s_bvalid && bready) begin
        s_bvalid <= 0;
        aw_have <= 0;
      end
      if (arvalid && arready) begin
        r_have <= 1;
        raddr <= araddr;
        rlen <= arlen;
        rcnt <= 0;
      end else if (r_have && (!s_rvalid || rready)) begin
        if (s_rvalid && s_rlast) begin
          r_have <= 0;
          s_rvalid <= 0;
        end else if (stall && $urandom_range(0, 3) == 0) s_rvalid <= 0;
        else begin
          s_rvalid <= 1;
          s_rdata <= smem[10'((raddr >> 2) + 16'(rcnt))];
          s_rlast <= rcnt == rlen || int'(rcnt) == early;
          s_rresp <= int'(rcnt) == err_beat ? 2'b10 : 2'b00;
          rcnt <= rcnt + 1;
        end
      end
    end
  end

  // compare process: every cycle, DUT outputs against the command-level expectation
  always @(negedge clk) begin
    if (rst) begin
      chk("cmd_ready_in_reset", cmd_ready, 0);
      w_seen = 0;
      r_seen = 0;
      idle_exp = 1;
      mm.delete();
    end else begin
      chk("busy", busy, !idle_exp);
      chk("cmd_ready", cmd_ready, idle_exp);
      if (active && cyc == acc_cyc)
        chk("addr_valid_latency", {awvalid, arvalid}, e_write ? 2'b10 : 2'b01);
      if (awvalid || arvalid)
        chk("addr_fields",
            awvalid ? {awvalid, arvalid, awaddr, awlen, awid, awsize, awburst, awlock, awcache, awprot}
                    : {awvalid, arvalid, araddr, arlen, arid, arsize, arburst, arlock, arcache, arprot},
            {e_write, !e_write, e_addr[15:2], 2'b00, e_len, e_id, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
      if (awvalid && awready) last_awaddr = awaddr;
      if (wvalid) begin
        chk("w_beat", {e_write, wlast, wstrb, wdata}, {1'b1, w_seen == int'(e_len), wr_strb, wr_data});
        if (wready) begin
          cix = ((int'(e_addr) >> 2) + w_seen) % 1024;
          cv = mm.exists(cix) ? mm[cix] : 32'h0;
          for (int b = 0; b < 4; b++) if (wr_strb[b]) cv[8*b +: 8] = wr_data[8*b +: 8];
          mm[cix] = cv;
          w_seen++;
        end
      end
      if (rd_valid) begin
        cix = ((int'(e_addr) >> 2) + r_seen) % 1024;
        cv = mm.exists(cix) ? mm[cix] : 32'h0;
        chk("rd_beat", {e_write, rd_last, rd_data}, {1'b0, r_seen == int'(e_len) || r_seen == early, cv});
        if (rd_ready) begin
          rd_log[r_seen[7:0]] = rd_data;
          last_rd_last = rd_last;
          r_seen++;
        end
      end
      if (done_valid) begin
        chk("done", {active, done_write, done_id, done_resp}, {1'b1, e_write, e_id, e_resp});
        if (lat_chk) chk("done_latency", cyc - acc_cyc, 3);
        last_resp = done_resp;
        done_cnt++;
        idle_exp = 1;
      end
      if (cmd_valid && cmd_ready) begin
        w_seen = 0;
        r_seen = 0;
        idle_exp = 0;
        acc_cyc = cyc + 1;
      end
    end
  end

  task automatic issue(input bit w, input logic [15:0] a, input logic [7:0] l, input logic [7:0] id,
                       input bit st, input int eb, input int el, input logic [1:0] br, input int rb,
                       input bit fixed, input logic [31:0] dv);
    int t, bi, d0;
    logic [31:0] wd;
    logic [3:0] ws;
    stall = st;
    err_beat = eb;
    early = el;
    bresp_cfg = br;
    e_write = w;
    e_addr = a;
    e_len = l;
    e_id = id;
    e_resp = w ? br : ((el >= 0 && el < int'(l)) || (eb >= 0 && eb <= int'(l))) ? 2'b10 : 2'b00;
    active = 1;
    d0 = done_cnt;
    cmd_valid = 1;
    cmd_write = w;
    cmd_addr = a;
    cmd_len = l;
    cmd_id = id;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    bi = 0;
    wd = fixed ? dv : $urandom;
    ws = (st && !fixed) ? 4'($urandom) : 4'hF;
    t = 0;
    while (w && bi <= int'(l) && t < 4000) begin
      wr_valid = !st || ($urandom_range(0, 2) != 0);
      wr_data = wd;
      wr_strb = ws;
      if (bi == rb) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        wr_valid = 0;
        active = 0;
        #1;
        chk_idle("post_reset_idle", 1);
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_cnt, d0);
        return;
      end
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        bi++;
        wd = fixed ? dv + 32'(bi) : $urandom;
        ws = (st && !fixed) ? 4'($urandom) : 4'hF;
      end
      @(posedge clk); #1;
      t++;
    end
    wr_valid = 0;
    t = 0;
    while (done_cnt == d0 && t < 4000) begin
      rd_ready = !st || ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      t++;
    end
    rd_ready = 0;
    chk("done_count", done_cnt, d0 + 1);
    chk("beat_count", w ? w_seen : r_seen, w ? int'(l) + 1 : ((el >= 0 && el < int'(l)) ? el + 1 : int'(l) + 1));
    active = 0;
    lat_chk = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset_state", 0);
    rst = 0;
    #1;
    chk_idle("idle_after_reset", 1);
    lat_chk = 1;
    issue(1, 16'h0010, 0, 8'h11, 0, -1, -1, 2'b00, -1, 1, 32'hDEADBEEF);
    issue(0, 16'h0010, 0, 8'h12, 0, -1, -1, 2'b00, -1, 0, 0);
    chk("single_read_data", rd_log[0], 32'hDEADBEEF);
    chk("single_read_last", last_rd_last, 1);
    chk("single_read_resp", last_resp, 2'b00);
    issue(1, 16'h0100, 15, 8'h21, 0, -1, -1, 2'b00, -1, 1, 0);
    issue(0, 16'h0100, 15, 8'h22, 1, -1, -1, 2'b00, -1, 0, 0);
    for (int i = 0; i < 16; i++) chk("burst16_data", rd_log[i], i);
    issue(1, 16'h0103, 0, 8'h31, 0, -1, -1, 2'b00, -1, 0, 0);
    chk("unaligned_awaddr", last_awaddr, 16'h0100);
    issue(1, 16'h0200, 7, 8'h41, 1, -1, -1, 2'b00, -1, 0, 0);
    issue(0, 16'h0200, 7, 8'h42, 1, -1, -1, 2'b00, -1, 0, 0);
    issue(1, 16'h0300, 3, 8'h51, 0, -1, -1, 2'b11, -1, 0, 0);
    chk("bresp_decerr", last_resp, 2'b11);
    issue(0, 16'h0300, 3, 8'h52, 0, 2, -1, 2'b00, -1, 0, 0);
    chk("rresp_slverr", last_resp, 2'b10);
    issue(0, 16'h0300, 3, 8'h53, 1, -1, 1, 2'b00, -1, 0, 0);
    chk("early_rlast_resp", last_resp, 2'b10);
    chk("early_rlast_beats", r_seen, 2);
    issue(1, 16'h0400, 7, 8'h61, 0, -1, -1, 2'b00, 3, 0, 0);
    issue(1, 16'h0400, 7, 8'h62, 1, -1, -1, 2'b01, -1, 0, 0);
    issue(0, 16'h0400, 7, 8'h63, 1, -1, -1, 2'b00, -1, 0, 0);
    for (int k = 0; k < 30; k++) begin
      logic [15:0] a;
      logic [7:0] l;
      int eb, el;
      a = 16'($urandom_range(0, 16'h0FFF));
      l = 8'($urandom_range(0, 15));
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l))) : -1;
      el = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l))) : -1;
      issue(1, a, l, 8'($urandom), 1, -1, -1, 2'($urandom), -1, 0, 0);
      issue(0, a, l, 8'($urandom), 1'($urandom), eb, el, 2'b00, -1, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
